systolic_stream_feeder: RTL and testbench

Host-side producer for the systolic array's input stream. It captures one full operand frame (array_width_p*array_height_p elements) from a host write port into a local flop buffer. On start, it streams the frame to the array over a valid/ready handshake. After a programmable quiet interval it issues the single-cycle flush that drains results from the array.

---
 rtl/systolic_stream_feeder.sv | 89 ++++++++
 tb/tb_systolic_stream_feeder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_stream_feeder.sv
// systolic_stream_feeder: buffers one operand frame from the host, streams it to the array, then flushes
module systolic_stream_feeder #(
  parameter int width_p = 8,
  parameter int array_width_p = 8,
  parameter int array_height_p = 8,
  parameter int flush_delay_p = 10,
  localparam int D = array_width_p * array_height_p,
  localparam int cw = $clog2(D + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               wr_valid_i,
  input  logic [width_p-1:0] wr_data_i,
  output logic               wr_ready_o,
  input  logic               start_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic               flush_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [cw-1:0]      count_o
);
  localparam int aw = D > 1 ? $clog2(D) : 1;
  localparam int dw = flush_delay_p > 1 ? $clog2(flush_delay_p) : 1;
  localparam logic [cw-1:0] last_c = cw'(D - 1);
  localparam logic [dw-1:0] dly_init_c = dw'(flush_delay_p > 0 ? flush_delay_p - 1 : 0);
  typedef enum logic [2:0] {FILL, ARMED, STREAM, WAIT, FLUSH, DONE} state_t;
  state_t state_q, state_n;
  logic [cw-1:0] cnt_q, cnt_n;
  logic [dw-1:0] dly_q, dly_n;
  logic [width_p-1:0] mem_q [D];
  logic [aw-1:0] ptr;
  assign ptr = aw'(cnt_q);
  assign wr_ready_o = state_q == FILL;
  assign valid_o = state_q == STREAM;
  assign data_o = valid_o ? mem_q[ptr] : '0;
  assign flush_o = state_q == FLUSH;
  assign done_o = state_q == DONE;
  assign busy_o = state_q inside {ARMED, STREAM, WAIT, FLUSH};
  assign count_o = cnt_q;
  // state, element counter (write or read pointer by phase) and flush delay counter
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= FILL;
      cnt_q <= '0;
      dly_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q <= cnt_n;
      dly_q <= dly_n;
    end
  end
  // frame buffer, deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (wr_ready_o && wr_valid_i) mem_q[ptr] <= wr_data_i;
  end
  // sequencing: fill, wait for start, stream, quiet interval, flush, done
  always_comb begin
    state_n = state_q;
    cnt_n = cnt_q;
    dly_n = dly_q;
    case (state_q)
      FILL: if (wr_valid_i) begin
        cnt_n = cnt_q + 1'b1;
        state_n = cnt_q == last_c ? ARMED : FILL;
      end
      ARMED: if (start_i) begin
        cnt_n = '0;
        state_n = STREAM;
      end
      STREAM: if (ready_i) begin
        cnt_n = cnt_q + 1'b1;
        dly_n = dly_init_c;
        state_n = cnt_q != last_c ? STREAM : flush_delay_p == 0 ? FLUSH : WAIT;
      end
      WAIT: begin
        dly_n = dly_q - 1'b1;
        state_n = dly_q == '0 ? FLUSH : WAIT;
      end
      FLUSH: state_n = DONE;
      DONE: begin
        cnt_n = '0;
        state_n = FILL;
      end
      default: state_n = FILL;
    endcase
  end
endmodule

// File: tb/tb_systolic_stream_feeder.sv
// tb_systolic_stream_feeder: randomized frame-level checks of the stream feeder against a queue model
module tb_systolic_stream_feeder;
  localparam int W = 8, D = 64, FD = 10, CW = 7;
  logic clk = 0, reset_n, reset0_n, wr_valid, start, ready, sel;
  logic [W-1:0] wr_data;
  logic a_wr_ready, a_valid, a_flush, a_busy, a_done;
  logic b_wr_ready, b_valid, b_flush, b_busy, b_done;
  logic [W-1:0] a_data, b_data;
  logic [CW-1:0] a_count, b_count;
  logic o_wr_ready, o_valid, o_flush, o_busy, o_done;
  logic [W-1:0] o_data;
  logic [CW-1:0] o_count;
  int checks = 0, errors = 0;
  logic [W-1:0] frame [$];

  systolic_stream_feeder #(.width_p(W), .array_width_p(8), .array_height_p(8), .flush_delay_p(FD)) dut (
    .clk_i(clk), .reset_i(reset_n), .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(a_wr_ready),
    .start_i(start), .valid_o(a_valid), .data_o(a_data), .ready_i(ready), .flush_o(a_flush),
    .busy_o(a_busy), .done_o(a_done), .count_o(a_count));
  systolic_stream_feeder #(.width_p(W), .array_width_p(8), .array_height_p(8), .flush_delay_p(0)) dut0 (
    .clk_i(clk), .reset_i(reset0_n), .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(b_wr_ready),
    .start_i(start), .valid_o(b_valid), .data_o(b_data), .ready_i(ready), .flush_o(b_flush),
    .busy_o(b_busy), .done_o(b_done), .count_o(b_count));

  assign o_wr_ready = sel ? b_wr_ready : a_wr_ready;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_data = sel ? b_data : a_data;
  assign o_flush = sel ? b_flush : a_flush;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_count = sel ? b_count : a_count;

  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 0;
    repeat (10) @(negedge clk);
    checks++;
    if ({o_wr_ready, o_valid, o_flush, o_busy, o_done} !== 5'b10000 || o_count !== '0 || o_data !== '0) begin
      errors++;
      $display("FAIL reset_hold got rdy/val/fl/busy/done=%b count=%0d data=%0h want 10000 0 0",
               {o_wr_ready, o_valid, o_flush, o_busy, o_done}, o_count, o_data);
    end
    reset_n = 1;
    @(negedge clk);
    checks++;
    if ({o_wr_ready, o_valid, o_flush, o_busy, o_done} !== 5'b10000 || o_count !== '0) begin
      errors++;
      $display("FAIL reset_release got %b count=%0d want 10000 0", {o_wr_ready, o_valid, o_flush, o_busy, o_done}, o_count);
    end
  endtask

  task automatic fill(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      checks++;
      if (o_wr_ready !== 1'b1 || o_count !== CW'(i)) begin
        errors++;
        $display("FAIL fill_%0d got ready=%b count=%0d want 1 %0d", i, o_wr_ready, o_count, i);
      end
      wr_valid = 1;
      wr_data = frame[i];
    end
    if (hi == D) begin
      @(negedge clk);
      wr_valid = 0;
      checks++;
      if (o_wr_ready !== 1'b0 || o_count !== CW'(D) || o_busy !== 1'b1 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL armed got ready=%b count=%0d busy=%b valid=%b want 0 %0d 1 0", o_wr_ready, o_count, o_busy, o_valid, D);
      end
    end
  endtask

  task automatic stream(input int mode, input int fd, input int abort_at);
    int idx = 0, cyc = 0;
    logic rdy;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    while (idx < D && cyc < 8 * D) begin
      if (cyc > 0) @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_data !== frame[idx] || o_count !== CW'(idx) || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d got valid=%b data=%0h count=%0d want 1 %0h %0d", idx, o_valid, o_data, o_count, frame[idx], idx);
      end
      rdy = mode == 0 ? 1'b1 : mode == 1 ? ((cyc % 2) == 0) : 1'($urandom);
      ready = rdy;
      if (rdy) idx++;
      cyc++;
      if (abort_at > 0 && idx == abort_at) begin
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_count !== '0 || o_flush !== 1'b0 || o_wr_ready !== 1'b1 || o_busy !== 1'b0) begin
          errors++;
          $display("FAIL async_abort got valid=%b count=%0d flush=%b ready=%b busy=%b want 0 0 0 1 0",
                   o_valid, o_count, o_flush, o_wr_ready, o_busy);
        end
        return;
      end
    end
    checks++;
    if (idx != D) begin
      errors++;
      $display("FAIL stream_timeout got %0d handshakes want %0d", idx, D);
    end
    if (mode == 1) begin
      checks++;
      if (cyc != 2 * D - 1) begin
        errors++;
        $display("FAIL toggle_cycles got %0d want %0d", cyc, 2 * D - 1);
      end
    end
    for (int j = 0; j <= fd + 2; j++) begin
      @(negedge clk);
      ready = 1'($urandom);
      checks++;
      if (o_flush !== (j == fd) || o_done !== (j == fd + 1) || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL tail_%0d got flush=%b done=%b valid=%b want %b %b 0", j, o_flush, o_done, o_valid, j == fd, j == fd + 1);
      end
      checks++;
      if (j <= fd + 1 ? (o_count !== CW'(D) || o_busy !== (j <= fd)) : (o_count !== '0 || o_busy !== 1'b0 || o_wr_ready !== 1'b1)) begin
        errors++;
        $display("FAIL tail_state_%0d got count=%0d busy=%b ready=%b", j, o_count, o_busy, o_wr_ready);
      end
    end
    ready = 0;
  endtask

  task automatic test_basic();
    frame.delete();
    for (int i = 0; i < D; i++) frame.push_back(W'(i + 1));
    fill(0, D);
    stream(0, FD, 0);
  endtask

  task automatic test_backpressure();
    frame.delete();
    for (int i = 0; i < D; i++) frame.push_back(W'($urandom));
    fill(0, D);
    stream(1, FD, 0);
  endtask

  task automatic test_back_to_back();
    frame.delete();
    for (int i = 0; i < D; i++) frame.push_back(W'($urandom));
    fill(0, D);
    stream(2, FD, 0);
  endtask

  task automatic test_ignored();
    frame.delete();
    for (int i = 0; i < D; i++) frame.push_back(W'($urandom));
    fill(0, 10);
    @(negedge clk);
    wr_valid = 0;
    start = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0 || o_count !== CW'(10) || o_wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL early_start got valid=%b count=%0d ready=%b want 0 10 1", o_valid, o_count, o_wr_ready);
      end
    end
    start = 0;
    fill(10, D);
    wr_valid = 1;
    wr_data = ~frame[0];
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (o_wr_ready !== 1'b0 || o_count !== CW'(D)) begin
        errors++;
        $display("FAIL excess_write got ready=%b count=%0d want 0 %0d", o_wr_ready, o_count, D);
      end
    end
    wr_valid = 0;
    stream(2, FD, 0);
  endtask

  task automatic test_flush_zero();
    sel = 1;
    reset0_n = 1;
    frame.delete();
    for (int i = 0; i < D; i++) frame.push_back(W'(i + 1));
    fill(0, D);
    stream(0, 0, 0);
    repeat (15) @(negedge clk);
    sel = 0;
    reset0_n = 0;
  endtask

  task automatic test_mid_reset();
    frame.delete();
    for (int i = 0; i < D; i++) frame.push_back(W'($urandom));
    fill(0, D);
    stream(0, FD, 20);
    ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_flush !== 1'b0 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_flush got flush=%b valid=%b want 0 0", o_flush, o_valid);
      end
    end
    reset_n = 1;
    frame.delete();
    for (int i = 0; i < D; i++) frame.push_back(W'(7));
    fill(0, D);
    stream(2, FD, 0);
  endtask

  initial begin
    wr_valid = 0;
    wr_data = '0;
    start = 0;
    ready = 0;
    sel = 0;
    reset0_n = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_ignored();
    test_flush_zero();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
